// File: rtl/slice_bit_packer.sv
// rtl/slice_bit_packer.sv - packs VLC codewords into 32-bit big-endian words through a small output FIFO
// Define SLICE_BIT_PACKER_SIZE_EN to enable the slice byte counter (slice_bytes / slice_done).
`timescale 1ns/1ps
module slice_bit_packer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        code_valid,
    input  logic [31:0] code_bits,
    input  logic [5:0]  code_len,
    input  logic        flush,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic [2:0]  out_bytes,
    input  logic        out_ready,
    output logic [31:0] slice_bytes,
    output logic        slice_done,
    output logic        overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    typedef enum logic {S_RUN, S_TAIL} state_t;

    state_t      state;
    state_t      state_next;
    logic [63:0] acc;
    logic [5:0]  bit_cnt;

    logic        take;
    logic [5:0]  eff_len;
    logic [31:0] len_mask;
    logic [63:0] code_aligned;
    logic [63:0] acc_app;
    logic [6:0]  cnt_app;

    logic        push;
    logic [31:0] push_word;
    logic        push_last;
    logic [2:0]  push_bytes;
    logic [63:0] acc_next;
    logic [5:0]  cnt_next;
    logic        finish;

    // acc bits below bit_cnt are always zero, so appending is a plain OR
    always_comb begin
        take     = code_valid && (state == S_RUN);
        eff_len  = (code_len > 6'd32) ? 6'd32 : code_len;
        if (!take)
            eff_len = '0;
        len_mask     = (eff_len == 6'd32) ? 32'hFFFF_FFFF : ((32'd1 << eff_len) - 32'd1);
        code_aligned = {code_bits & len_mask, 32'd0} << (6'd32 - eff_len);
        acc_app      = acc | (code_aligned >> bit_cnt);
        cnt_app      = {1'b0, bit_cnt} + {1'b0, eff_len};
    end

    always_comb begin
        push       = 1'b0;
        push_word  = acc_app[63:32];
        push_last  = 1'b0;
        push_bytes = 3'd4;
        acc_next   = acc_app;
        cnt_next   = cnt_app[5:0];
        finish     = 1'b0;
        state_next = state;
        if (state == S_TAIL) begin
            push       = 1'b1;
            push_word  = acc[63:32];
            push_last  = 1'b1;
            push_bytes = 3'((bit_cnt + 6'd7) >> 3);
            acc_next   = '0;
            cnt_next   = '0;
            finish     = 1'b1;
            state_next = S_RUN;
        end else begin
            if (cnt_app >= 7'd32) begin
                push     = 1'b1;
                acc_next = acc_app << 32;
                cnt_next = 6'(cnt_app - 7'd32);
            end
            // a flush that leaves no remainder closes the slice on this edge
            if (flush) begin
                if (cnt_next != 6'd0) begin
                    state_next = S_TAIL;
                end else begin
                    finish    = 1'b1;
                    push_last = push;
                end
            end
        end
    end

    logic [35:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic          pop;
    logic          wr_en;

    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign wr_en     = push && ((count != DEPTH_C) || pop);
    assign {out_last, out_bytes, out_data} = mem[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= S_RUN;
            acc      <= '0;
            bit_cnt  <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
        end else begin
            state   <= state_next;
            acc     <= acc_next;
            bit_cnt <= cnt_next;
            if (wr_en) begin
                mem[wr_ptr] <= {push_last, push_bytes, push_word};
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(wr_en) - (AW+1)'(pop);
            if (push && !wr_en)
                overflow <= 1'b1;
        end
    end

`ifdef SLICE_BIT_PACKER_SIZE_EN
    logic [31:0] byte_cnt;
    logic [31:0] byte_sum;

    // dropped words still count toward the slice length
    assign byte_sum = byte_cnt + (push ? {29'd0, push_bytes} : 32'd0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            byte_cnt    <= '0;
            slice_bytes <= '0;
            slice_done  <= 1'b0;
        end else begin
            slice_done <= finish;
            if (finish) begin
                slice_bytes <= byte_sum;
                byte_cnt    <= '0;
            end else begin
                byte_cnt <= byte_sum;
            end
        end
    end
`else
    logic finish_unused;
    assign finish_unused = finish;
    assign slice_bytes   = '0;
    assign slice_done    = 1'b0;
`endif

endmodule

// File: tb/tb_slice_bit_packer.sv
// tb/tb_slice_bit_packer.sv - directed self-checking bench for slice_bit_packer
`timescale 1ns/1ps
module tb_slice_bit_packer;
`ifdef SLICE_BIT_PACKER_SIZE_EN
    localparam bit SIZE_EN = 1'b1;
`else
    localparam bit SIZE_EN = 1'b0;
`endif
    localparam int DEPTH = 4;

    logic        clock;
    logic        reset;
    logic        code_valid;
    logic [31:0] code_bits;
    logic [5:0]  code_len;
    logic        flush;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_last;
    logic [2:0]  out_bytes;
    logic        out_ready;
    logic [31:0] slice_bytes;
    logic        slice_done;
    logic        overflow;

    slice_bit_packer #(.FIFO_DEPTH(DEPTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .code_valid  (code_valid),
        .code_bits   (code_bits),
        .code_len    (code_len),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_last    (out_last),
        .out_bytes   (out_bytes),
        .out_ready   (out_ready),
        .slice_bytes (slice_bytes),
        .slice_done  (slice_done),
        .overflow    (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    logic [35:0] got_q [$];
    int done_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // accepted words and slice_done pulses, sampled on the falling edge
    always @(negedge clock) begin
        if (!reset) begin
            if (out_valid && out_ready)
                got_q.push_back({out_last, out_bytes, out_data});
            if (slice_done)
                done_cnt++;
        end
    end

    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    task automatic send(input int len, input logic [31:0] bits, input logic fl);
        code_valid = 1'b1;
        code_len   = len[5:0];
        code_bits  = bits;
        flush      = fl;
        cyc();
        code_valid = 1'b0;
        code_len   = '0;
        code_bits  = '0;
        flush      = 1'b0;
    endtask

    task automatic flush_only();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic clear_obs();
        got_q.delete();
        done_cnt = 0;
    endtask

    task automatic expect_word(input string tag, input int idx, input logic [31:0] d,
                               input logic l, input logic [2:0] b);
        logic [35:0] w;
        w = 'x;
        if (idx < got_q.size())
            w = got_q[idx];
        check({tag, ".data"},  {32'd0, w[31:0]}, {32'd0, d});
        check({tag, ".last"},  {63'd0, w[35]},   {63'd0, l});
        check({tag, ".bytes"}, {61'd0, w[34:32]}, {61'd0, b});
    endtask

    initial begin
        reset      = 1'b1;
        code_valid = 1'b0;
        code_bits  = '0;
        code_len   = '0;
        flush      = 1'b0;
        out_ready  = 1'b1;
        cyc();
        cyc();
        check("rst.out_valid",   out_valid,   0);
        check("rst.out_data",    out_data,    0);
        check("rst.out_last",    out_last,    0);
        check("rst.out_bytes",   out_bytes,   0);
        check("rst.slice_bytes", slice_bytes, 0);
        check("rst.slice_done",  slice_done,  0);
        check("rst.overflow",    overflow,    0);
        reset = 1'b0;
        clear_obs();

        // two 16-bit codes form one full word
        send(16, 32'h0000_ABCD, 1'b0);
        send(16, 32'h0000_1234, 1'b0);
        repeat (4) cyc();
        check("t1.nwords", got_q.size(), 1);
        expect_word("t1.w0", 0, 32'hABCD_1234, 1'b0, 3'd4);
        check("t1.ndone", done_cnt, 0);

        do_reset();
        clear_obs();

        // 3+5 bits, then flush: one-byte tail; upper code bits must be ignored
        send(3, 32'hFFFF_FFF5, 1'b0);
        send(5, 32'h0000_0003, 1'b0);
        flush_only();
        check("t2.done_early", slice_done, 0);
        cyc();
        check("t2.done",  slice_done,  SIZE_EN);
        check("t2.sbytes", slice_bytes, SIZE_EN ? 1 : 0);
        repeat (4) cyc();
        check("t2.nwords", got_q.size(), 1);
        expect_word("t2.w0", 0, 32'hA300_0000, 1'b1, 3'd1);
        clear_obs();

        // 40 bits with flush on the second codeword
        send(32, 32'hFFFF_FFFF, 1'b0);
        send(8,  32'h0000_005A, 1'b1);
        repeat (5) cyc();
        check("t3.nwords", got_q.size(), 2);
        expect_word("t3.w0", 0, 32'hFFFF_FFFF, 1'b0, 3'd4);
        expect_word("t3.w1", 1, 32'h5A00_0000, 1'b1, 3'd1);
        check("t3.sbytes", slice_bytes, SIZE_EN ? 5 : 0);
        check("t3.ndone", done_cnt, SIZE_EN ? 1 : 0);
        clear_obs();

        // empty flush: no word, slice_bytes goes back to 0
        flush_only();
        repeat (3) cyc();
        check("t6.nwords", got_q.size(), 0);
        check("t6.ndone",  done_cnt, SIZE_EN ? 1 : 0);
        check("t6.sbytes", slice_bytes, 0);
        clear_obs();

        // overflow: DEPTH+1 words with out_ready low
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            send(32, 32'h1000_0000 + i, 1'b0);
        check("t4.ovf_at_full", overflow, 0);
        send(32, 32'h1000_0000 + DEPTH, 1'b0);
        check("t4.ovf", overflow, 1);
        check("t4.head_hold", out_data, 32'h1000_0000);
        check("t4.valid_hold", out_valid, 1);
        out_ready = 1'b1;
        send(8, 32'h0000_00EE, 1'b1);
        repeat (8) cyc();
        check("t4.nwords", got_q.size(), DEPTH + 1);
        for (int i = 0; i < DEPTH; i++)
            expect_word($sformatf("t4.w%0d", i), i, 32'h1000_0000 + i, 1'b0, 3'd4);
        expect_word("t4.tail", DEPTH, 32'hEE00_0000, 1'b1, 3'd1);
        check("t4.sbytes", slice_bytes, SIZE_EN ? (DEPTH + 1) * 4 + 1 : 0);
        check("t4.ovf_sticky", overflow, 1);

        // reset mid-slice with 20 bits buffered
        send(20, 32'h000F_FFFF, 1'b0);
        reset = 1'b1;
        cyc();
        check("t5.rst_valid", out_valid, 0);
        check("t5.rst_ovf",   overflow,  0);
        reset = 1'b0;
        clear_obs();
        send(32, 32'h0102_0304, 1'b0);
        repeat (4) cyc();
        check("t5.nwords", got_q.size(), 1);
        expect_word("t5.w0", 0, 32'h0102_0304, 1'b0, 3'd4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
